if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Generates the PC and runs a request/acknowledge transaction with instruction memory (variable latency).
- Presents if_pc/if_inst to IF/ID, and requests a pipeline stall from ctrl while a fetch is outstanding.
- Honours branch redirects (with delay slot), exception flush to new_pc, and ctrl stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, instruction address width (InstAddrBus).
- DATA_W, 32, instruction width (InstBus).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  ctrl stall vector; bit0 = PC/fetch stage.
- flush  in  1  exception flush; redirect to new_pc.
- new_pc  in  ADDR_W  exception handler address, valid with flush.
- branch_flag_i  in  1  ID resolved a taken branch/jump.
- branch_target_address_i  in  ADDR_W  branch target, valid with branch_flag_i.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; word aligned (bits[1:0]=0).
- imem_ack  in  1  one-cycle response strobe.
- imem_rdata  in  DATA_W  instruction data, valid with imem_ack.
- if_pc  out  ADDR_W  PC of the presented instruction.
- if_inst  out  DATA_W  presented instruction; ZeroWord (nop) when not valid.
- stallreq_if  out  1  stall request to ctrl while the instruction is not yet valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - Registers: pc=RESET_PC, state=IDLE, pend_br=0, drop=0, inst_buf=0.
  - Outputs: imem_req=0, imem_addr=0, if_pc=0, if_inst=0, stallreq_if=0.
- Reset mid-transaction abandons the request; a late ack after release is ignored while in IDLE.
- States: IDLE, REQ, VALID.
- IDLE: first cycle after reset release; next state REQ. No request issued, stallreq_if=0.
- REQ:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - stallreq_if=1; if_inst=0; if_pc=pc.
  - On imem_ack with drop=0: inst_buf<=imem_rdata, next state VALID.
  - On imem_ack with drop=1: discard data, drop<=0, stay in REQ; the new address is driven the next cycle.
- VALID: if_pc=pc, if_inst=inst_buf, stallreq_if=0, imem_req=0.
  - stall[0]=NoStop advances the PC, next state REQ. Next PC, in priority order:
    - branch_flag_i ? branch_target_address_i
    - pend_br ? pend_tgt
    - else pc+4
  - Advancing clears pend_br.
  - stall[0]=Stop: hold pc, inst_buf and all outputs.
- Minimum latency: 1-cycle ack gives one instruction every 2 cycles (REQ, VALID). Back-to-back overlap is not required.
- Delay slot: branch_flag_i asserted while in REQ captures pend_br<=1, pend_tgt<=target. The instruction in flight (delay slot) is still delivered; the target is applied on the next advance.
- flush (priority over branch and stall):
  - pc<=new_pc; pend_br<=0; inst_buf invalidated.
  - In REQ with no ack this cycle: drop<=1, stay REQ.
  - In REQ with ack this cycle: discard the data, stay REQ with the new pc.
  - In VALID or IDLE: next state REQ.
- Simultaneous flush and branch_flag_i: flush wins; the branch is lost.
- Simultaneous flush and an ack of the dropped request: drop stays 1 only if a further request is still outstanding. A single outstanding request is allowed, so drop<=0.
- imem_ack outside REQ: ignored.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- Unaligned new_pc/target: bits[1:0] are forced to 0 on imem_addr. The alignment exception belongs to a later stage.

Decomposition:
- Shared defines package (alongside the existing one):
  - fetch state encodings FS_IDLE/FS_REQ/FS_VALID.
  - RESET_PC default.
  - Stop/NoStop and ZeroWord already exist.
- One natural sub-module: if_next_pc, the combinational next-PC priority mux (flush, branch, pending, +4). The FSM stays in the top module.

Test Plan:
- Reset release, imem_ack one cycle after each req, returning 32'h1111_0000+addr:
  - imem_addr sequence 0,4,8.
  - if_inst valid every 2nd cycle; stallreq_if high during each REQ.
- In VALID with stall[0]=1 for 3 cycles: if_pc/if_inst held constant, no imem_req.
  - On release: next req at pc+4.
- In VALID at pc=0x10, branch_flag_i=1, target 0x80: next imem_addr=0x80.
- Branch at 0x20 asserted while the 0x24 fetch is in REQ:
  - 0x24 is delivered.
  - The following fetch is at the target 0x100, not 0x28.
- Flush with new_pc=0x180 while the req for 0x40 is outstanding; ack arrives 3 cycles later with 0xDEAD_BEEF:
  - Data discarded, never visible on if_inst.
  - Next imem_addr=0x180.
- rst asserted while in REQ: all outputs 0 asynchronously.
  - After release, the first req is at RESET_PC; a stray ack in IDLE is ignored.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared defines for the instruction-fetch stage.
//   Stop / NoStop        : polarity of a ctrl stall bit
//   ZeroWord             : nop instruction presented when nothing is valid
//   DEFAULT_RESET_PC     : default boot address
//   FS_IDLE/FS_REQ/FS_VALID : fetch state encodings
package if_fetch_unit_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_REQ   = 2'd1;
  localparam logic [1:0] FS_VALID = 2'd2;

endpackage

// File: rtl/if_fetch_unit_next_pc.sv
// if_next_pc: combinational next-PC priority select for the fetch stage.
//   flush, new_pc             : exception redirect (highest priority)
//   branch_flag, branch_target: branch resolved in ID this cycle
//   pend_br, pend_tgt         : branch captured during an earlier fetch (delay slot)
//   pc                        : current PC, incremented by 4 otherwise
//   next_pc                   : selected PC (modulo 2^ADDR_W)
module if_next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              pend_br,
  input  logic [ADDR_W-1:0] pend_tgt,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb
    next_pc = flush       ? new_pc :
              branch_flag ? branch_target :
              pend_br     ? pend_tgt :
                            pc + ADDR_W'(4);

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
//   clk, rst (async, active-low)
//   stall[0]                         : hold the fetch stage when Stop
//   flush, new_pc                    : exception redirect
//   branch_flag_i, branch_target_address_i : taken branch from ID
//   imem_req/imem_addr/imem_ack/imem_rdata : single-outstanding memory handshake
//   if_pc, if_inst                   : instruction presented to IF/ID
//   stallreq_if                      : stall request while a fetch is outstanding
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_if
);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc, pend_tgt, req_addr, next_pc, pc_d;
  logic [DATA_W-1:0] inst_buf;
  logic              pend_br, drop;
  logic              in_idle, in_req, in_valid;
  logic              advance, ack_req, issue;
  logic              unused_stall;

  assign unused_stall = ^stall[5:1];

  assign in_idle  = state == FS_IDLE;
  assign in_req   = state == FS_REQ;
  assign in_valid = state == FS_VALID;

  assign advance = in_valid && stall[0] != Stop && !flush;
  assign ack_req = in_req && imem_ack;
  // A new address goes out on leaving IDLE/VALID, or once the in-flight
  // request completes but its data is unwanted (earlier or current flush).
  assign issue   = in_idle || (in_valid && (flush || stall[0] == NoStop)) ||
                   (ack_req && (drop || flush));

  if_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag_i),
    .branch_target (branch_target_address_i),
    .pend_br       (pend_br),
    .pend_tgt      (pend_tgt),
    .pc            (pc),
    .next_pc       (next_pc)
  );

  assign pc_d = (flush || advance) ? next_pc : pc;

  always_comb
    state_nxt = in_req   ? ((ack_req && !drop && !flush) ? FS_VALID : FS_REQ) :
                in_valid ? ((flush || stall[0] == NoStop) ? FS_REQ : FS_VALID) :
                           FS_REQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
      pend_br  <= 1'b0;
      pend_tgt <= '0;
      drop     <= 1'b0;
      inst_buf <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_d;
      // Low address bits are dropped here; misalignment is reported later.
      if (issue)
        req_addr <= {pc_d[ADDR_W-1:2], 2'b00};
      // Flush without a response leaves the old request outstanding; its ack
      // must be swallowed before the redirected fetch is issued.
      drop <= (in_req && flush && !imem_ack) ? 1'b1 :
              ack_req                        ? 1'b0 : drop;
      // A branch seen while fetching the delay slot is applied on the next advance.
      pend_br <= (flush || advance)          ? 1'b0 :
                 (in_req && branch_flag_i)   ? 1'b1 : pend_br;
      if (in_req && branch_flag_i && !flush)
        pend_tgt <= branch_target_address_i;
      if (flush)
        inst_buf <= '0;
      else if (ack_req && !drop)
        inst_buf <= imem_rdata;
    end
  end

  assign imem_req    = in_req;
  assign imem_addr   = in_req ? req_addr : '0;
  assign stallreq_if = in_req;
  assign if_pc       = in_idle ? '0 : pc;
  assign if_inst     = in_valid ? inst_buf : DATA_W'(ZeroWord);

endmodule
